// File: rtl/pkt_rx_endpoint.sv
// Receive endpoint for the DEST/LEN/payload/CSUM byte stream: buffers one payload,
// validates it, and holds it for an indexed reader until acknowledged.
module pkt_rx_endpoint #(
    parameter logic [7:0] MY_ADDR = 8'h01,
    parameter int         MAX_LEN = 16,
    parameter int         AW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          pkt_valid,
    output logic [1:0]    pkt_err,
    output logic [7:0]    pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          pkt_ack,
    output logic [15:0]   pkt_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_PAY   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        rdy;
    logic [1:0]  err;
    logic [7:0]  len;
    logic [15:0] cnt_ok;
    logic [7:0]  dest;
    logic [7:0]  xacc;
    logic [7:0]  cnt;
    logic [7:0]  mem [2**AW];
    logic        xfer;
    logic        len_bad;
    logic [1:0]  csum_stat;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Checksum mismatch outranks a wrong destination.
    function automatic logic [1:0] frame_status(input logic [7:0] csum_byte,
                                                input logic [7:0] acc,
                                                input logic [7:0] d);
        if (csum_byte != acc) return 2'd1;
        if (d != MY_ADDR)     return 2'd3;
        return 2'd0;
    endfunction

    assign xfer      = in_valid && rdy;
    assign len_bad   = (in_data == 8'd0) || (in_data > MAX_LEN_B);
    assign csum_stat = frame_status(in_data, xacc, dest);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (xfer) state_nxt = S_LEN;
            S_LEN:   if (xfer) state_nxt = len_bad ? S_DRAIN : S_PAY;
            S_PAY:   if (xfer && (cnt == len - 8'd1)) state_nxt = S_CSUM;
            S_DRAIN: if (xfer && (cnt == 8'd0)) state_nxt = S_HOLD;
            S_CSUM:  if (xfer) state_nxt = S_HOLD;
            S_HOLD:  if (pkt_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // in_ready is registered from the next state so HOLD already blocks the edge it is entered on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            rdy    <= 1'b0;
            err    <= 2'd0;
            len    <= 8'd0;
            cnt_ok <= 16'd0;
        end else begin
            state <= state_nxt;
            rdy   <= (state_nxt != S_HOLD);
            if (xfer) begin
                case (state)
                    S_IDLE: err <= 2'd0;
                    S_LEN: begin
                        len <= in_data;
                        if (len_bad) err <= 2'd2;
                    end
                    S_CSUM: begin
                        err <= csum_stat;
                        if (csum_stat == 2'd0) cnt_ok <= sat_inc(cnt_ok);
                    end
                    default: ;
                endcase
            end
        end
    end

    // cnt is the write index in PAY and the remaining-bytes count in DRAIN.
    always_ff @(posedge clk) begin
        if (xfer) begin
            case (state)
                S_IDLE: begin
                    dest <= in_data;
                    xacc <= in_data;
                end
                S_LEN: begin
                    xacc <= xacc ^ in_data;
                    cnt  <= len_bad ? in_data : 8'd0;
                end
                S_PAY: begin
                    mem[cnt[AW-1:0]] <= in_data;
                    xacc             <= xacc ^ in_data;
                    cnt              <= cnt + 8'd1;
                end
                S_DRAIN: cnt <= cnt - 8'd1;
                default: ;
            endcase
        end
    end

    assign in_ready  = rdy;
    assign pkt_valid = (state == S_HOLD);
    assign pkt_err   = err;
    assign pkt_len   = len;
    assign pkt_cnt   = cnt_ok;
    assign rd_data   = mem[rd_addr];

endmodule

// File: tb/tb_pkt_rx_endpoint.sv
// Directed bench for pkt_rx_endpoint: frames are modelled into a scoreboard when
// sent, and each held packet is popped and compared against that model.
module tb_pkt_rx_endpoint;

    localparam logic [7:0] MY = 8'h01;
    localparam int         AW = 4;

    typedef struct packed {
        logic [1:0]   err;
        logic [7:0]   len;
        logic [127:0] pay;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          pkt_valid;
    logic [1:0]    pkt_err;
    logic [7:0]    pkt_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_ack;
    logic [15:0]   pkt_cnt;

    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    exp_t sb[$];

    pkt_rx_endpoint #(.MY_ADDR(MY), .MAX_LEN(16), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pkt_valid(pkt_valid), .pkt_err(pkt_err),
        .pkt_len(pkt_len), .rd_addr(rd_addr), .rd_data(rd_data),
        .pkt_ack(pkt_ack), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] fr[$]);
        logic [7:0] x;
        x = 8'h00;
        foreach (fr[i]) x = x ^ fr[i];
        return x;
    endfunction

    function automatic exp_t model(input logic [7:0] fr[$]);
        exp_t       e;
        logic [7:0] x;
        int         n;
        n = fr.size();
        e = '0;
        x = 8'h00;
        for (int i = 0; i < n - 1; i++) x = x ^ fr[i];
        e.len = fr[1];
        for (int i = 0; i < 16 && i < int'(fr[1]) && i < n - 3; i++) e.pay[i*8 +: 8] = fr[2+i];
        if (fr[1] == 8'd0 || fr[1] > 8'd16) e.err = 2'd2;
        else if (fr[n-1] != x)              e.err = 2'd1;
        else if (fr[0] != MY)               e.err = 2'd3;
        else                                e.err = 2'd0;
        return e;
    endfunction

    task automatic send(input logic [7:0] fr[$], input int gap_pct, input bit push,
                        input bit keep_valid, input logic [7:0] next_byte, output int first_wait);
        if (push) sb.push_back(model(fr));
        first_wait = 0;
        foreach (fr[i]) begin
            int   g;
            int   n;
            logic acc;
            g = 0;
            while (gap_pct > 0 && g < 6 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
                @(posedge clk); #1;
                g++;
            end
            in_valid = 1'b1;
            in_data  = fr[i];
            n = 0;
            do begin
                acc = in_ready;
                @(posedge clk); #1;
                n++;
            end while (!acc && n < 200);
            if (!acc) check("xfer_timeout", 32'(acc), 32'd1);
            if (i == 0) first_wait = n;
        end
        in_valid = keep_valid;
        in_data  = next_byte;
    endtask

    task automatic expect_pkt(input int ack_delay);
        exp_t e;
        int   n;
        n = 0;
        while (!pkt_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("pkt_valid_latency", 32'(n), 32'd0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("pkt_err", 32'(pkt_err), 32'(e.err));
        check("pkt_len", 32'(pkt_len), 32'(e.len));
        if (e.err == 2'd0) exp_cnt++;
        check("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
        if (e.err != 2'd2) begin
            for (int i = 0; i < int'(e.len); i++) begin
                rd_addr = i[AW-1:0];
                #1;
                check("rd_data", 32'(rd_data), 32'(e.pay[i*8 +: 8]));
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < ack_delay; k++) begin
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(pkt_valid), 32'd1);
            @(posedge clk); #1;
        end
        pkt_ack = 1'b1;
        @(posedge clk); #1;
        pkt_ack = 1'b0;
        check("ack_valid", 32'(pkt_valid), 32'd0);
        check("ack_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] fb[$];
        int         fw;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; rd_addr = '0; pkt_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_err", 32'(pkt_err), 32'd0);
        check("rst_len", 32'(pkt_len), 32'd0);
        check("rst_cnt", 32'(pkt_cnt), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Good frame, bad checksum, misaddressed.
        fr = '{8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDF};
        send(fr, 0, 1'b1, 1'b0, 8'h00, fw);
        expect_pkt(0);
        fr = '{8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        send(fr, 0, 1'b1, 1'b0, 8'h00, fw);
        expect_pkt(0);
        fr = '{8'h02, 8'h01, 8'h55, 8'h56};
        send(fr, 0, 1'b1, 1'b0, 8'h00, fw);
        expect_pkt(0);

        // Over-long and zero length frames are drained whole.
        fr = '{8'h01, 8'h14};
        for (int i = 0; i < 20; i++) fr.push_back(8'(i * 3 + 1));
        fr.push_back(xsum(fr));
        send(fr, 0, 1'b1, 1'b0, 8'h00, fw);
        expect_pkt(0);
        fr = '{8'h01, 8'h00, 8'h01};
        send(fr, 0, 1'b1, 1'b0, 8'h00, fw);
        expect_pkt(0);

        // Back-to-back with in_valid held high across a delayed ack.
        fr = '{8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        fb = '{8'h01, 8'h01, 8'h42, 8'h42};
        send(fr, 0, 1'b1, 1'b1, fb[0], fw);
        expect_pkt(5);
        send(fb, 0, 1'b1, 1'b0, 8'h00, fw);
        check("b2b_dest_wait", 32'(fw), 32'd1);
        expect_pkt(0);

        // Full-length frame without and with random idle gaps.
        fr = '{8'h01, 8'h10};
        for (int i = 0; i < 16; i++) fr.push_back(8'(i * 7 + 3));
        fr.push_back(xsum(fr));
        send(fr, 0, 1'b1, 1'b0, 8'h00, fw);
        expect_pkt(0);
        send(fr, 50, 1'b1, 1'b0, 8'h00, fw);
        expect_pkt(0);

        // Reset in the middle of a frame, then a clean one-byte frame.
        fr = '{8'h01, 8'h04, 8'h11, 8'h22};
        send(fr, 0, 1'b0, 1'b0, 8'h00, fw);
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_valid", 32'(pkt_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 0;
        check("midrst_cnt", 32'(pkt_cnt), 32'd0);
        fr = '{8'h01, 8'h01, 8'h7E, 8'h7E};
        send(fr, 0, 1'b1, 1'b0, 8'h00, fw);
        expect_pkt(0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pkt_rx_endpoint.md
Name: pkt_rx_endpoint

Overview:
- Synthesizable receive endpoint for the byte-framed packet stream that dut_top emits on an output port.
- Accepts the stream over a valid/ready handshake and buffers one packet's payload.
- Checks address, length and XOR checksum, then exposes the packet to a reader through an indexed read port and an acknowledge handshake.
- Instantiated in the bench top on each DUT output so that DUT egress has a real, back-pressuring consumer.

Parameters:
- MY_ADDR, 8'h01, port address; packets whose destination byte differs are flagged as misaddressed.
- MAX_LEN, 16, maximum payload length in bytes (1..255).
- AW, 4, payload buffer address width; must satisfy 2**AW >= MAX_LEN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  endpoint can accept a byte this cycle.
- pkt_valid  output  1  a complete packet is held and awaiting acknowledge.
- pkt_err  output  2  status of held packet: 0 ok, 1 checksum, 2 bad length, 3 misaddressed.
- pkt_len  output  8  payload length of held packet.
- rd_addr  input  AW  payload byte index.
- rd_data  output  8  payload byte at rd_addr, combinational read.
- pkt_ack  input  1  reader releases the held packet.
- pkt_cnt  output  16  count of packets completed with status ok; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, immediate): FSM to IDLE; in_ready=0 while reset is asserted and 1 in the first cycle after release; pkt_valid=0, pkt_err=0, pkt_len=0, pkt_cnt=0.
- Buffer contents are not reset. rd_data is don't-care when pkt_valid=0.
- A byte transfers on a rising edge when in_valid && in_ready.
- Frame format: DEST, LEN, LEN payload bytes, CSUM. CSUM = XOR of DEST, LEN and all payload bytes.
- FSM states:
  - IDLE: on transfer, latch DEST, initialise running XOR = DEST, go to LEN.
  - LEN: on transfer, latch LEN and XOR it in.
    - LEN==0 or LEN>MAX_LEN: set error 2, go to DRAIN.
    - Otherwise clear the write index and go to PAY.
  - PAY: each transfer writes buf[idx], XORs the byte in, increments idx; after the LEN-th byte go to CSUM.
  - DRAIN: consume and discard exactly LEN bytes plus 1 (CSUM), no buffer writes, then go to HOLD with pkt_len=LEN.
    - For LEN==0, DRAIN consumes the single CSUM byte only.
  - CSUM: on transfer, compare the byte with the running XOR, then go to HOLD. Status priority: checksum mismatch → 1; else DEST!=MY_ADDR → 3; else 0.
  - HOLD: pkt_valid=1, in_ready=0. On pkt_ack go to IDLE and drop pkt_valid the next cycle. pkt_ack outside HOLD is ignored.
- in_ready is 1 in IDLE, LEN, PAY, DRAIN and CSUM; 0 in HOLD.
- in_ready is a registered output only: it cannot depend combinationally on in_valid.
- pkt_cnt increments by 1 on entry to HOLD with status 0; it is held at 16'hFFFF once reached.
- Latency:
  - pkt_valid asserts the cycle after the CSUM byte transfers.
  - Minimum packet-to-packet time is LEN+3 transfer cycles plus 1 HOLD cycle when pkt_ack is held high.
- in_valid low in any state inserts idle cycles; the FSM holds with no state change.
- in_data is ignored whenever in_valid=0 or in_ready=0.
- Reset mid-packet: the partial packet is abandoned, and the next accepted byte after release is treated as DEST.
- pkt_ack asserted in the same cycle pkt_valid rises is honoured in the following cycle, i.e. HOLD lasts at least 1 cycle.

Test Plan:
- Reset, then frame 01,03,AA,BB,CC,CSUM=01^03^AA^BB^CC=DF → pkt_valid=1 next cycle, pkt_err=0, pkt_len=3, rd_addr 0/1/2 reads AA/BB/CC, pkt_cnt=1; pkt_ack → pkt_valid=0, in_ready=1.
- Same frame with CSUM=00 → pkt_err=1, pkt_cnt stays 0; frame 02,01,55,CSUM=56 → pkt_err=3.
- LEN=0x14 (20>16) with 20 payload bytes and a CSUM byte → pkt_err=2, pkt_len=20, all 23 bytes consumed, next byte accepted as DEST. LEN=0 → 3 bytes consumed, pkt_err=2.
- Two back-to-back valid frames with in_valid held high and pkt_ack withheld 5 cycles → in_ready=0 throughout HOLD, second frame's DEST transfers the cycle after the ack is processed, no byte lost, pkt_cnt=2.
- Random in_valid gaps (50%) inside a MAX_LEN=16 frame → identical payload readback and status as the gapless case.
- Assert reset after the 2nd payload byte of a 4-byte frame, then send a clean 1-byte frame → only the clean frame is reported, pkt_len=1, pkt_err=0.
